// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU that reuses one bit-slice over WIDTH cycles,
// LSB first, with a carry flop standing in for the ripple chain. The MSB
// cycle applies the MSB-slice rules (set, overflow) and commits the result.
module serial_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [3:0]       alu_ctl,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);

   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       ctl_q, ctl_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   // Bit-slice datapath signals; operands shift right so bit 0 is the current bit.
   logic             ai, bi, sum_bit, cout, res_bit, ovf_raw, set_bit;
   logic [WIDTH-1:0] final_res;

   // One bit-slice: inverts, full adder, operation mux and MSB-slice rules.
   always_comb begin
      ai      = a_q[0] ^ ctl_q[3];
      bi      = b_q[0] ^ ctl_q[2];
      sum_bit = ai ^ bi ^ carry_q;
      cout    = (ai & bi) | ((ai ^ bi) & carry_q);
      unique case (ctl_q[1:0])
         2'b00:   res_bit = ai & bi;
         2'b01:   res_bit = ai | bi;
         2'b10:   res_bit = sum_bit;
         default: res_bit = 1'b0;
      endcase
      // Only meaningful on the MSB cycle, where a_q[0]/b_q[0] hold the raw sign bits.
      ovf_raw   = carry_q ^ cout;
      set_bit   = ovf_raw ? (a_q[0] & ~b_q[0]) : sum_bit;
      final_res = {res_bit, sh_q[WIDTH-1:1]};
      if (ctl_q[1:0] == 2'b11) begin
         final_res = {{(WIDTH-1){1'b0}}, set_bit};
      end
   end

   // Controller next-state and register updates; everything holds by default.
   always_comb begin
      // NOTE: every _d gets a default first so no path through the case infers a latch.
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      ctl_d    = ctl_q;
      sh_d     = sh_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               a_d     = src_a;
               b_d     = src_b;
               ctl_d   = alu_ctl;
               idx_d   = '0;
               carry_d = alu_ctl[2];
               sh_d    = '0;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = cout;
            sh_d    = {res_bit, sh_q[WIDTH-1:1]};
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_BIT) begin
               state_d  = DONE;
               result_d = final_res;
               zero_d   = (final_res == '0);
               ovf_d    = (ctl_q[1:0] == 2'b11) ? 1'b0 : ovf_raw;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset; reset also aborts a running operation.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         ctl_q    <= '0;
         sh_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctl_q    <= ctl_d;
         sh_q     <= sh_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed tests for serial_alu at WIDTH=32.
module tb_serial_alu;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] src_a, src_b;
   logic [3:0]   alu_ctl;
   logic         busy, done, zero, overflow;
   logic [W-1:0] result;

   int total = 0;
   int bad   = 0;

   serial_alu #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .src_a    (src_a),
      .src_b    (src_b),
      .alu_ctl  (alu_ctl),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .zero     (zero),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   ctl;
      logic [W-1:0] r;
      logic         ov;
   } vec_t;

   // Wait (bounded) until the DUT is back in IDLE.
   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Issue one operation and wait for done; lat = edges from accept to done.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] ctl, output int lat, output logic busy_ok);
      wait_idle();
      @(negedge clk);
      src_a = a; src_b = b; alu_ctl = ctl; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && lat < 200) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; src_a = '0; src_b = '0; alu_ctl = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (result !== '0)     begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
      total++; if (zero !== 1'b1)     begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
      rst = 1'b0;
   endtask

   task automatic test_add();
      int lat;
      logic bok;
      run_op(32'd5, 32'd7, 4'b0010, lat, bok);
      total++; if (lat !== W)         begin bad++; $display("FAIL add_latency got=%0d exp=%0d", lat, W); end
      total++; if (bok !== 1'b1)      begin bad++; $display("FAIL add_busy got=%b exp=1", bok); end
      total++; if (result !== 32'hC)  begin bad++; $display("FAIL add_result got=%h exp=0000000c", result); end
      total++; if (zero !== 1'b0)     begin bad++; $display("FAIL add_zero got=%b exp=0", zero); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL add_ovf got=%b exp=0", overflow); end
      @(posedge clk); #1;
      total++; if (done !== 1'b0)     begin bad++; $display("FAIL add_done_pulse got=%b exp=0", done); end
      total++; if (result !== 32'hC)  begin bad++; $display("FAIL add_hold got=%h exp=0000000c", result); end
   endtask

   task automatic test_vectors();
      vec_t v [11];
      int lat;
      logic bok;
      v[0]  = '{32'h00000003, 32'h00000005, 4'b0110, 32'hFFFFFFFE, 1'b0}; // SUB
      v[1]  = '{32'h00000009, 32'h00000009, 4'b0110, 32'h00000000, 1'b0}; // SUB to zero
      v[2]  = '{32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b1}; // ADD ovf
      v[3]  = '{32'h80000000, 32'h00000001, 4'b0110, 32'h7FFFFFFF, 1'b1}; // SUB ovf
      v[4]  = '{32'h80000000, 32'h00000001, 4'b0111, 32'h00000001, 1'b0}; // SLT ovf path
      v[5]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0111, 32'h00000000, 1'b0}; // SLT ovf path
      v[6]  = '{32'h00000002, 32'h00000005, 4'b0111, 32'h00000001, 1'b0}; // SLT
      v[7]  = '{32'h0F0F0000, 32'h00F0F000, 4'b1100, 32'hF0000FFF, 1'b0}; // NOR
      v[8]  = '{32'h0000000A, 32'h00000005, 4'b0001, 32'h0000000F, 1'b0}; // OR
      v[9]  = '{32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 32'h0F000F00, 1'b0}; // AND
      v[10] = '{32'h80000000, 32'h80000000, 4'b0000, 32'h80000000, 1'b1}; // AND, adder ovf
      for (int i = 0; i < 11; i++) begin
         run_op(v[i].a, v[i].b, v[i].ctl, lat, bok);
         total++; if (result !== v[i].r) begin bad++; $display("FAIL vec%0d_result got=%h exp=%h", i, result, v[i].r); end
         total++; if (zero !== (v[i].r == '0)) begin bad++; $display("FAIL vec%0d_zero got=%b exp=%b", i, zero, (v[i].r == '0)); end
         total++; if (overflow !== v[i].ov) begin bad++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, overflow, v[i].ov); end
      end
   endtask

   task automatic test_ignore_start();
      int n = 0;
      int extra = 0;
      wait_idle();
      @(negedge clk);
      src_a = 32'h12345678; src_b = 32'h11111111; alu_ctl = 4'b0010; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      src_a = 32'h0; alu_ctl = 4'b0110; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL ignore_timeout got=%b exp=1", done); end
      total++; if (result !== 32'h23456789) begin bad++; $display("FAIL ignore_result got=%h exp=23456789", result); end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL ignore_extra_done got=%0d exp=0", extra); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int m = 0;
      wait_idle();
      @(negedge clk);
      src_a = 32'd1; src_b = 32'd2; alu_ctl = 4'b0010; start = 1'b1;
      @(posedge clk); #1;
      src_a = 32'd100; src_b = 32'd1; alu_ctl = 4'b0110;
      while (done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      total++; if (n !== W)           begin bad++; $display("FAIL b2b_lat1 got=%0d exp=%0d", n, W); end
      total++; if (result !== 32'd3)  begin bad++; $display("FAIL b2b_res1 got=%h exp=00000003", result); end
      do begin @(posedge clk); #1; m++; end while (done !== 1'b1 && m < 200);
      start = 1'b0;
      total++; if (m !== W + 2)       begin bad++; $display("FAIL b2b_period got=%0d exp=%0d", m, W + 2); end
      total++; if (result !== 32'h63) begin bad++; $display("FAIL b2b_res2 got=%h exp=00000063", result); end
   endtask

   task automatic test_reset_abort();
      int seen = 0;
      int lat;
      logic bok;
      wait_idle();
      @(negedge clk);
      src_a = 32'd5; src_b = 32'd7; alu_ctl = 4'b0010; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      total++; if (result !== '0)     begin bad++; $display("FAIL abort_result got=%h exp=0", result); end
      total++; if (zero !== 1'b1)     begin bad++; $display("FAIL abort_zero got=%b exp=1", zero); end
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) seen++;
         @(posedge clk); #1;
      end
      total++; if (seen !== 0)        begin bad++; $display("FAIL abort_done got=%0d exp=0", seen); end
      run_op(32'd1, 32'd1, 4'b0010, lat, bok);
      total++; if (result !== 32'd2)  begin bad++; $display("FAIL abort_recover got=%h exp=00000002", result); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_vectors();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
